priority_request_scheduler: RTL and testbench

//  Sequences nine active-low interrupt/key request lines into one-at-a-time grants with a valid/ack handshake.

---
 rtl/priority_request_scheduler_if.sv | 23 ++
 rtl/priority_request_scheduler.sv | 119 +++++++++++
 tb/tb_priority_request_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/priority_request_scheduler_if.sv
// Request/grant bundle between raw request pins, the scheduler and the grant consumer.
// grant_vld/grant_ack: a grant is held stable while grant_vld=1 and retires on the cycle grant_ack=1.
interface priority_request_scheduler_if;
  logic [8:0] req_n;
  logic       en;
  logic       rr_mode;
  logic       grant_ack;
  logic       grant_vld;
  logic [3:0] grant_code_n;
  logic [8:0] grant_onehot;
  logic [8:0] pending;
  logic       drop_err;

  modport master (
    output req_n, en, rr_mode, grant_ack,
    input  grant_vld, grant_code_n, grant_onehot, pending, drop_err
  );

  modport slave (
    input  req_n, en, rr_mode, grant_ack,
    output grant_vld, grant_code_n, grant_onehot, pending, drop_err
  );
endinterface

// File: rtl/priority_request_scheduler.sv
// Captures falling edges on nine active-low request pins into a sticky pending set and
// issues one grant at a time (fixed priority or round-robin), with a post-ack holdoff.
module priority_request_scheduler #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_CYC = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  priority_request_scheduler_if.slave       bus,
  output logic [1:0]                        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] sync_q [SYNC_STAGES];
  logic [8:0] prev_q;
  logic [8:0] pending_q, pending_d;
  logic       drop_q, drop_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] rr_ptr_q;
  logic [3:0] cnt_q;
  logic [8:0] fall;
  logic [8:0] onehot;
  logic [8:0] clr;
  logic       ack_take;

  // Highest set index wins.
  function automatic logic [3:0] fixed_pick(input logic [8:0] p);
    logic [3:0] w;
    w = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (p[i]) w = 4'(i);
    end
    return w;
  endfunction

  // Candidates ordered ptr-1, ptr-2, ... wrapping 0->8, ptr last; the nearest one is assigned last.
  function automatic logic [3:0] rr_pick(input logic [8:0] p, input logic [3:0] ptr);
    logic [4:0] pos;
    logic [3:0] w;
    w = ptr;
    for (int k = 9; k >= 1; k--) begin
      pos = 5'(ptr) + 5'(9 - k);
      if (pos >= 5'd9) pos = pos - 5'd9;
      if (p[pos[3:0]]) w = pos[3:0];
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
      prev_q <= '1;
    end else begin
      sync_q[0] <= bus.req_n;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall     = prev_q & ~sync_q[SYNC_STAGES-1];
  assign onehot   = 9'b1 << idx_q;
  assign ack_take = (state_q == GRANT) && bus.grant_ack;
  assign clr      = ack_take ? onehot : 9'd0;

  // A bit cleared by this ack and re-armed in the same cycle is a fresh request, not a drop.
  always_comb begin
    pending_d = (pending_q & ~clr) | fall;
    drop_d    = |(fall & pending_q & ~clr);
    idx_d     = bus.rr_mode ? rr_pick(pending_q, rr_ptr_q) : fixed_pick(pending_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      drop_q    <= 1'b0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
      if (state_q == IDLE && state_d == GRANT) idx_q <= idx_d;
      if (ack_take) rr_ptr_q <= idx_q;
      cnt_q <= (state_q == HOLDOFF) ? cnt_q + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en && (pending_q != 9'd0)) state_d = GRANT;
      GRANT:   if (bus.grant_ack) state_d = (HOLDOFF_CYC == 0) ? IDLE : HOLDOFF;
      HOLDOFF: if (cnt_q == 4'(HOLDOFF_CYC - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registers, so req_n never reaches them combinationally.
  always_comb begin
    bus.grant_vld    = (state_q == GRANT);
    bus.grant_onehot = bus.grant_vld ? onehot : 9'd0;
    bus.grant_code_n = bus.grant_vld ? ~(idx_q + 4'd1) : 4'b1111;
    bus.pending      = pending_q;
    bus.drop_err     = drop_q;
    dbg_state_o      = state_q;
  end

endmodule

// File: tb/tb_priority_request_scheduler.sv
// Directed bench for priority_request_scheduler: expected grants are queued by the driver
// and popped by an independent monitor on every rising grant_vld.
module tb_priority_request_scheduler;

  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  priority_request_scheduler_if bus ();

  priority_request_scheduler #(.SYNC_STAGES(2), .HOLDOFF_CYC(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  logic [12:0] exp_q[$];
  logic [12:0] mon_e;
  logic        prev_vld = 1'b0;
  int          drop_cnt = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [8:0] bits, input int low_cyc);
    bus.req_n = bus.req_n & ~bits;
    tick(low_cyc);
    bus.req_n = bus.req_n | bits;
  endtask

  task automatic wait_grant();
    int cyc;
    cyc = 0;
    while (bus.grant_vld !== 1'b1 && cyc < 100) begin
      tick(1);
      cyc++;
    end
    chk("grant_seen", bus.grant_vld, 1);
  endtask

  task automatic ack(input logic [8:0] rereq);
    bus.grant_ack = 1'b1;
    bus.req_n     = bus.req_n & ~rereq;
    tick(1);
    bus.grant_ack = 1'b0;
    tick(1);
    bus.req_n     = bus.req_n | rereq;
  endtask

  // Monitor: every new grant must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.drop_err === 1'b1) drop_cnt++;
      if (bus.grant_vld === 1'b1 && !prev_vld) begin
        chk("grant_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("grant_code_n", bus.grant_code_n, mon_e[12:9]);
          chk("grant_onehot", bus.grant_onehot, mon_e[8:0]);
        end
      end
      prev_vld = (bus.grant_vld === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int d0;
    int hits;
    logic [8:0] rr_rereq [6];
    rr_rereq = '{9'h100, 9'h020, 9'h001, 9'h000, 9'h000, 9'h000};

    // T1 reset
    bus.req_n = 9'h1FF; bus.en = 1'b0; bus.rr_mode = 1'b0; bus.grant_ack = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("rst_grant_vld", bus.grant_vld, 0);
    chk("rst_code_n", bus.grant_code_n, 4'b1111);
    chk("rst_onehot", bus.grant_onehot, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_drop_err", bus.drop_err, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick(2);
    chk("post_rst_pending", bus.pending, 0);

    // T2 fixed priority: 7 beats 2
    bus.en = 1'b1;
    exp_q.push_back({4'b0111, 9'h080});
    exp_q.push_back({4'b1100, 9'h004});
    pulse(9'h084, 2);
    wait_grant();
    chk("t2_pending_both", bus.pending, 9'h084);
    bus.grant_ack = 1'b1;
    tick(1);
    bus.grant_ack = 1'b0;
    gap = 0;
    while (bus.grant_vld !== 1'b1 && gap < 20) begin
      gap++;
      tick(1);
    end
    chk("t2_holdoff_gap", (gap >= HOLD) && (gap <= HOLD + 1), 1);
    chk("t2_pending_after_ack", bus.pending, 9'h004);
    ack(9'h000);
    tick(4);
    chk("t2_pending_clear", bus.pending, 0);

    // T3 round-robin from a fresh rr_ptr
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.rr_mode = 1'b1;
    exp_q.push_back({4'b0110, 9'h100});
    exp_q.push_back({4'b1001, 9'h020});
    exp_q.push_back({4'b1110, 9'h001});
    exp_q.push_back({4'b0110, 9'h100});
    exp_q.push_back({4'b1001, 9'h020});
    exp_q.push_back({4'b1110, 9'h001});
    pulse(9'h121, 2);
    for (int g = 0; g < 6; g++) begin
      wait_grant();
      ack(rr_rereq[g]);
    end
    tick(4);
    chk("t3_pending_clear", bus.pending, 0);

    // T4 second edge on a pending bit
    bus.rr_mode = 1'b0;
    d0 = drop_cnt;
    exp_q.push_back({4'b1011, 9'h008});
    pulse(9'h008, 2);
    tick(2);
    pulse(9'h008, 2);
    tick(4);
    chk("t4_pending_held", bus.pending, 9'h008);
    wait_grant();
    ack(9'h000);
    tick(10);
    chk("t4_drop_pulses", drop_cnt - d0, 1);
    chk("t4_pending_clear", bus.pending, 0);

    // T5 en gating and capture latency
    bus.en = 1'b0;
    bus.req_n[4] = 1'b0;
    tick(2);
    chk("t5_capture_early", bus.pending, 0);
    tick(1);
    chk("t5_capture_latency", bus.pending, 9'h010);
    bus.req_n[4] = 1'b1;
    hits = 0;
    repeat (10) begin
      tick(1);
      if (bus.grant_vld === 1'b1) hits++;
    end
    chk("t5_gated_grants", hits, 0);
    exp_q.push_back({4'b1010, 9'h010});
    bus.en = 1'b1;
    tick(1);
    chk("t5_grant_after_en", bus.grant_vld, 1);
    ack(9'h000);
    tick(4);

    // T6 reset while granting
    bus.en = 1'b0;
    pulse(9'h101, 2);
    tick(2);
    chk("t6_pending", bus.pending, 9'h101);
    exp_q.push_back({4'b0110, 9'h100});
    bus.en = 1'b1;
    wait_grant();
    chk("t6_state_grant", dbg_state, 1);
    rst = 1'b1;
    tick(1);
    chk("t6_grant_vld", bus.grant_vld, 0);
    chk("t6_pending", bus.pending, 0);
    chk("t6_code_n", bus.grant_code_n, 4'b1111);
    chk("t6_onehot", bus.grant_onehot, 0);
    rst = 1'b0;
    tick(10);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
